// File: rtl/mmio_bridge.sv
// mmio_bridge: routes processor data accesses to RAM or a bank of output, switch and counter registers
// with a uniform one-cycle read latency.
module mmio_bridge #(
  parameter int                ADDR_W          = 12,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE       = 12'hF00,
  parameter int                NUM_OUT         = 4,
  parameter int                NUM_SW          = 5,
  parameter int                DEBOUNCE_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic                      cpu_wren,
  input  logic                      cpu_rden,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_rdata,
  input  logic [NUM_SW-1:0]         sw_in,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  output logic [NUM_SW-1:0]         sw_state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] A_SW   = ADDR_W'(NUM_OUT);
  localparam logic [ADDR_W-1:0] A_EDGE = ADDR_W'(NUM_OUT + 1);
  localparam logic [ADDR_W-1:0] A_CYC  = ADDR_W'(NUM_OUT + 2);

  logic              w_is_mmio;
  logic [ADDR_W-1:0] w_off;
  logic [DATA_W-1:0] w_mmio_rd;
  logic [NUM_SW-1:0] w_flip, w_rise;
  logic              w_clr;
  logic [DATA_W-1:0] r_out [NUM_OUT];
  logic [NUM_SW-1:0] r_s1, r_s2, r_sw, r_edge;
  logic [CW-1:0]     r_cnt [NUM_SW];
  logic [DATA_W-1:0] r_cyc, r_rd;
  logic              r_sel_mmio;

  assign w_is_mmio = cpu_addr >= MMIO_BASE;
  assign w_off     = cpu_addr - MMIO_BASE;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren && !w_is_mmio;
  assign cpu_rdata = r_sel_mmio ? r_rd : ram_rdata;
  assign sw_state  = r_sw;
  assign w_clr     = cpu_rden && w_is_mmio && w_off == A_EDGE;
  assign w_rise    = w_flip & ~r_sw;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*DATA_W +: DATA_W] = r_out[g];
  end

  // A bit flips on the cycle its counter would reach DEBOUNCE_CYCLES, giving 2+DEBOUNCE_CYCLES latency.
  for (genvar b = 0; b < NUM_SW; b++) begin : g_flip
    assign w_flip[b] = r_s2[b] != r_sw[b] && r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1);
  end

  always_comb begin
    w_mmio_rd = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (w_off == ADDR_W'(i)) w_mmio_rd = r_out[i];
    if (w_off == A_SW)   w_mmio_rd = DATA_W'(r_sw);
    if (w_off == A_EDGE) w_mmio_rd = DATA_W'(r_edge);
    if (w_off == A_CYC)  w_mmio_rd = r_cyc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
      for (int i = 0; i < NUM_SW; i++) r_cnt[i] <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_sw       <= '0;
      r_edge     <= '0;
      r_cyc      <= '0;
      r_rd       <= '0;
      r_sel_mmio <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (cpu_wren && w_is_mmio && w_off == ADDR_W'(i)) r_out[i] <= cpu_wdata;
      for (int i = 0; i < NUM_SW; i++)
        r_cnt[i] <= (r_s2[i] == r_sw[i] || w_flip[i]) ? '0 : r_cnt[i] + CW'(1);
      r_s1       <= sw_in;
      r_s2       <= r_s1;
      r_sw       <= r_sw ^ w_flip;
      r_edge     <= (w_clr ? '0 : r_edge) | w_rise;
      r_cyc      <= r_cyc + DATA_W'(1);
      r_rd       <= w_mmio_rd;
      r_sel_mmio <= w_is_mmio;
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed and random stimulus for mmio_bridge against a transaction-level reference model.
module tb_mmio_bridge;
  localparam int AW = 12, DW = 32, NO = 4, NS = 5, DEB = 16;
  localparam logic [AW-1:0] BASE = 12'hF00;

  logic             clock = 1'b0;
  logic             reset;
  logic [AW-1:0]    cpu_addr, ram_addr;
  logic [DW-1:0]    cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic             cpu_wren, cpu_rden, ram_wren;
  logic [NS-1:0]    sw_in, sw_state;
  logic [NO*DW-1:0] out_regs;

  logic [DW-1:0] ram   [4096];
  logic [DW-1:0] m_mem [4096];
  logic [DW-1:0] m_out [NO];
  logic [NS-1:0] hist  [DEB+2];
  logic [NS-1:0] m_sw, m_edge;
  logic [DW-1:0] m_cyc, m_rd, c1;
  logic          m_rvalid;
  int            n_chk = 0, n_err = 0;

  always #5 clock = ~clock;

  mmio_bridge #(.ADDR_W(AW), .DATA_W(DW), .MMIO_BASE(BASE), .NUM_OUT(NO), .NUM_SW(NS),
                .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata), .sw_in(sw_in),
    .out_regs(out_regs), .sw_state(sw_state)
  );

  always @(posedge clock) begin
    if (ram_wren) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NO; i++) m_out[i] = '0;
    for (int i = 0; i < DEB + 2; i++) hist[i] = '0;
    m_sw = '0;
    m_edge = '0;
    m_cyc = '0;
    m_rvalid = 1'b0;
  endtask

  // A switch bit changes once the last DEB synchronised samples (input delayed two cycles) all disagree with it.
  task automatic model_edge();
    int off;
    logic [NS-1:0] flip;
    if (!reset) begin
      model_reset();
      return;
    end
    off = int'(cpu_addr) - int'(BASE);
    if (cpu_addr < BASE) m_rd = m_mem[cpu_addr];
    else if (off < NO) m_rd = m_out[off];
    else if (off == NO) m_rd = DW'(m_sw);
    else if (off == NO + 1) m_rd = DW'(m_edge);
    else if (off == NO + 2) m_rd = m_cyc;
    else m_rd = '0;
    m_rvalid = 1'b1;
    if (cpu_wren && cpu_addr < BASE) m_mem[cpu_addr] = cpu_wdata;
    if (cpu_wren && off >= 0 && off < NO) m_out[off] = cpu_wdata;
    for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sw_in;
    flip = '1;
    for (int j = 2; j < DEB + 2; j++) flip &= hist[j] ^ m_sw;
    if (cpu_rden && off == NO + 1) m_edge = '0;
    m_edge |= flip & ~m_sw;
    m_sw ^= flip;
    m_cyc++;
  endtask

  task automatic check_all();
    if (m_rvalid) chk("rdata", cpu_rdata, m_rd);
    else chk("rdata_rst", cpu_rdata, ram_rdata);
    chk("ram_wren", DW'(ram_wren), DW'(cpu_wren && cpu_addr < BASE));
    chk("ram_addr", DW'(ram_addr), DW'(cpu_addr));
    chk("ram_wdata", ram_wdata, cpu_wdata);
    for (int i = 0; i < NO; i++) chk($sformatf("out%0d", i), out_regs[i*DW +: DW], m_out[i]);
    chk("sw_state", DW'(sw_state), DW'(m_sw));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w, input logic r);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_wren = w;
    cpu_rden = r;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    reset = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
    sw_in = '0;
    model_reset();
    #1;
    chk("rst_out0", out_regs[DW-1:0], 32'd0);
    chk("rst_sw", DW'(sw_state), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    op(BASE, 32'h0000A5A5, 1'b1, 1'b0);
    chk("t1_ram_wren", DW'(ram_wren), 32'd0);
    chk("t1_out0", out_regs[DW-1:0], 32'h0000A5A5);
    op(BASE, 32'd0, 1'b0, 1'b1);
    chk("t1_readback", cpu_rdata, 32'h0000A5A5);

    op(12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("t2_ram_wren", DW'(ram_wren), 32'd1);
    op(12'h010, 32'd0, 1'b0, 1'b1);
    chk("t2_readback", cpu_rdata, 32'hDEADBEEF);
    chk("t2_out0", out_regs[DW-1:0], 32'h0000A5A5);
    chk("t2_ram_wren_off", DW'(ram_wren), 32'd0);

    sw_in[2] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      op(12'h000, 32'd0, 1'b0, 1'b0);
      if (k == 17) chk("t3_sw2_early", DW'(sw_state[2]), 32'd0);
    end
    chk("t3_sw2_latency", DW'(sw_state[2]), 32'd1);
    sw_in[0] = 1'b1;
    repeat (10) op(12'h000, 32'd0, 1'b0, 1'b0);
    sw_in[0] = 1'b0;
    repeat (20) op(12'h000, 32'd0, 1'b0, 1'b0);
    chk("t3_glitch", DW'(sw_state[0]), 32'd0);

    op(BASE + 12'd5, 32'd0, 1'b0, 1'b1);
    chk("t4_edge", cpu_rdata, 32'h4);
    op(BASE + 12'd5, 32'd0, 1'b0, 1'b1);
    chk("t4_cleared", cpu_rdata, 32'h0);
    sw_in[1] = 1'b1;
    repeat (17) op(12'h000, 32'd0, 1'b0, 1'b0);
    op(BASE + 12'd5, 32'd0, 1'b0, 1'b1);
    chk("t4_clr_same", cpu_rdata, 32'h0);
    op(BASE + 12'd5, 32'hFFFFFFFF, 1'b1, 1'b1);
    chk("t4_set_wins", cpu_rdata, 32'h2);

    op(BASE + 12'd6, 32'd0, 1'b0, 1'b1);
    c1 = cpu_rdata;
    repeat (9) op(12'h000, 32'd0, 1'b0, 1'b0);
    op(BASE + 12'd6, 32'd0, 1'b0, 1'b1);
    chk("t5_cyc_delta", cpu_rdata - c1, 32'd10);
    op(BASE + 12'd7, 32'h55AA55AA, 1'b1, 1'b0);
    op(BASE + 12'd7, 32'd0, 1'b0, 1'b1);
    chk("t5_unmapped", cpu_rdata, 32'd0);
    op(BASE + 12'd4, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("t5_sw_ro", DW'(sw_state), 32'h6);
    op(BASE + 12'd4, 32'd0, 1'b0, 1'b1);
    chk("t5_sw_read", cpu_rdata, 32'h6);

    op(BASE + 12'd1, 32'h00001234, 1'b1, 1'b0);
    sw_in[3] = 1'b1;
    repeat (18) op(12'h000, 32'd0, 1'b0, 1'b0);
    op(BASE, 32'd0, 1'b0, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NO; i++) chk($sformatf("t6_out%0d", i), out_regs[i*DW +: DW], 32'd0);
    chk("t6_sw", DW'(sw_state), 32'd0);
    chk("t6_rsel", cpu_rdata, ram_rdata);
    tick();
    reset = 1'b1;
    op(BASE + 12'd6, 32'd0, 1'b0, 1'b1);
    chk("t6_cyc", cpu_rdata, 32'd0);
    op(BASE + 12'd5, 32'd0, 1'b0, 1'b1);
    chk("t6_edge", cpu_rdata, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 39) == 0) sw_in[$urandom_range(0, NS-1)] ^= 1'b1;
      a = ($urandom_range(0, 3) < 2) ? AW'($urandom_range(0, 15)) :
          ($urandom_range(0, 3) == 0) ? BASE + AW'($urandom_range(0, 255)) : BASE + AW'($urandom_range(0, 7));
      op(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Memory-mapped I/O bridge between the processor data-memory port and the data RAM, plus a parametrised bank of board peripherals.
- Peripherals: NUM_OUT writable output registers (LED, 7-seg value, VGA dot X/Y, ...), debounced switch inputs, rising-edge event latch, free-running cycle counter.
- Sits at top level between processor dmem port and RAM; gives the processor uniform one-cycle read latency across all targets.

Parameters:
- ADDR_W, 12, width of the processor/RAM word address.
- DATA_W, 32, data word width.
- MMIO_BASE, 12'hF00, first MMIO word address; addresses below it go to RAM.
- NUM_OUT, 4, number of output registers (1..16).
- NUM_SW, 5, number of switch inputs (1..DATA_W).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles before a switch state change is accepted (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  processor word address.
- cpu_wdata  in  DATA_W  processor write data.
- cpu_wren  in  1  processor write strobe.
- cpu_rden  in  1  processor read qualifier; only qualified reads have side effects.
- cpu_rdata  out  DATA_W  read data, valid one cycle after address.
- ram_addr  out  ADDR_W  RAM address, equals cpu_addr.
- ram_wdata  out  DATA_W  RAM write data, equals cpu_wdata.
- ram_wren  out  1  cpu_wren AND (cpu_addr < MMIO_BASE).
- ram_rdata  in  DATA_W  RAM synchronous read data (one-cycle latency).
- sw_in  in  NUM_SW  raw asynchronous switch inputs.
- out_regs  out  NUM_OUT*DATA_W  flattened output registers; register i at bits [i*DATA_W +: DATA_W].
- sw_state  out  NUM_SW  debounced switch state.

Behaviour:
- Address map:
  - < MMIO_BASE: RAM.
  - MMIO_BASE+i, i<NUM_OUT: OUT[i], read/write.
  - MMIO_BASE+NUM_OUT: SW_STATE, read-only, zero-extended.
  - MMIO_BASE+NUM_OUT+1: SW_EDGE, read-to-clear.
  - MMIO_BASE+NUM_OUT+2: CYCLES, read-only.
  - All other MMIO addresses: unmapped; read 0, writes ignored.
- Reset (async, reset=0): out_regs=0, sw_state=0, sync flops=0, debounce counters=0, SW_EDGE=0, CYCLES=0, cpu_rdata select=RAM, cpu_rdata=ram_rdata path.
- RAM path is combinational pass-through. ram_wren is never asserted for addresses >= MMIO_BASE.
- Writes: on a clock edge with cpu_wren=1 and a matching OUT[i] address, OUT[i] <= cpu_wdata. out_regs updates in the same cycle. Writes to read-only or unmapped addresses have no effect.
- Reads:
  - Select and MMIO value are registered at clock edge N; cpu_rdata presents them during cycle N+1.
  - If the registered select is RAM, cpu_rdata = ram_rdata; otherwise it is the registered MMIO value.
  - Read-after-write to the same OUT[i] in the next cycle returns the new value.
- Switch path:
  - Two-flop synchroniser per bit.
  - Per-bit counter of width clog2(DEBOUNCE_CYCLES+1). Counter increments while the synced value differs from sw_state, and clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES, sw_state bit toggles and the counter clears.
  - Total latency from a stable input change to sw_state = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- SW_EDGE:
  - Bit sets when the corresponding sw_state bit goes 0->1 and is sticky.
  - A qualified read (cpu_rden=1 at the SW_EDGE address) returns the current value and clears it at that edge.
  - Simultaneous clear and new edge: the new edge bit remains set (set wins).
  - cpu_wren to SW_EDGE is ignored.
- CYCLES: DATA_W-bit counter incrementing every cycle, wraps from all-ones to 0.
- Reset mid-operation: all state returns to reset values immediately. A read in flight returns a RAM-select value after reset release.

Test Plan:
- Reset, then write 32'h0000A5A5 to MMIO_BASE+0, read it back next cycle -> cpu_rdata=32'h0000A5A5 one cycle after address; out_regs[31:0]=32'h0000A5A5; ram_wren stays 0.
- Write 32'hDEADBEEF to address 12'h010, read it back -> ram_wren=1 for one cycle; read returns RAM data with one-cycle latency; out_regs unchanged.
- Hold sw_in[2]=1 -> sw_state[2]=1 exactly 18 cycles later (default DEBOUNCE_CYCLES=16); a 10-cycle pulse on sw_in[0] -> sw_state[0] stays 0.
- After sw_state[2] rises, qualified read of SW_EDGE (MMIO_BASE+5) -> returns 32'h4, subsequent read returns 0. A rising edge on the same cycle as the clear -> bit stays set.
- Read CYCLES twice, 10 cycles apart -> difference = 10. Read MMIO_BASE+7 (unmapped) -> returns 0. Write to MMIO_BASE+4 -> SW_STATE unchanged.
- Assert reset mid-sequence with OUT[1]=32'h1234 -> all out_regs=0, SW_EDGE=0, CYCLES=0 asynchronously, before the next clock edge.
